// File: rtl/ysyx_25060173_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_25060173_ifu_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } ifu_state_e;

  // addi x0, x0, 0 -- presented whenever no real instruction is available
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // One buffered fetch result as seen by the decoder
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{inst: NOP_INST, pc: 32'h0, fault: 1'b0};

  // Sequential PC; wraps naturally modulo 2^32
  function automatic logic [31:0] pc_step(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Word fetches need the two low PC bits clear
  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25060173_fetch_fifo.sv
// Small synchronous FIFO holding fetched entries. A flush empties it on the
// same edge; a push on that edge lands as the single remaining entry.
module ysyx_25060173_fetch_fifo
  import ysyx_25060173_ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;
  logic [DEPTH-1:0] w_we;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  // A pop frees the slot this cycle, so push into a full FIFO is fine then
  assign w_do_push = push & (~full | w_do_pop);

  // Per-slot write enables; after a flush the write restarts at slot 0
  always_comb begin
    w_we = '0;
    if (flush) begin
      w_we[0] = push;
    end else if (w_do_push) begin
      w_we[r_wr_ptr] = 1'b1;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= EMPTY_ENTRY;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we[i]) r_mem[i] <= push_data;
      end
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= push ? AW'(1) : '0;
      r_count  <= push ? CW'(1) : '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/ysyx_25060173_inst_fetch.sv
// Instruction fetch unit: owns the PC, issues one word read at a time to
// instruction memory and buffers results for the decoder. Redirects flush
// the buffer; a response already in flight at redirect time is discarded.
module ysyx_25060173_inst_fetch
  import ysyx_25060173_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_M1 = CW'(FIFO_DEPTH - 1);

  ifu_state_e    r_state;
  ifu_state_e    w_state_next;
  logic [31:0]   r_pc;
  logic [31:0]   r_req_pc;
  logic          r_pending;
  logic          r_drop;

  logic          w_hs;
  logic          w_resp;
  logic          w_inflight;
  logic          w_misaligned;
  logic          w_push;
  logic          w_pop;
  logic          w_credit;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;

  // Request accepted this cycle
  assign w_hs         = (r_state == REQ) & imem_req_ready;
  // Response belonging to our outstanding request (late ones after reset are ignored)
  assign w_resp       = r_pending & imem_resp_valid;
  // A request is still outstanding after this edge
  assign w_inflight   = w_hs | (r_pending & ~imem_resp_valid);
  assign w_misaligned = redirect_valid & is_misaligned(redirect_pc[1:0]);
  // A response arriving together with a redirect is stale as well
  assign w_push       = (w_resp & ~r_drop & ~redirect_valid) | w_misaligned;
  assign w_pop        = ~w_empty & inst_ready & ~redirect_valid;

  // Credit: room in the buffer once this cycle's push/pop have taken effect
  always_comb begin
    w_credit = ~w_full;
    unique case ({w_push, w_pop})
      2'b10:   w_credit = (w_count < DEPTH_M1);
      2'b01:   w_credit = 1'b1;
      default: w_credit = ~w_full;
    endcase
  end

  // Entry to buffer: bus errors and misaligned targets both become faulting NOPs
  always_comb begin
    w_push_entry.inst  = imem_resp_err ? NOP_INST : imem_resp_data;
    w_push_entry.pc    = r_req_pc;
    w_push_entry.fault = imem_resp_err;
    if (w_misaligned) begin
      w_push_entry.inst  = NOP_INST;
      w_push_entry.pc    = redirect_pc;
      w_push_entry.fault = 1'b1;
    end
  end

  // Next-state logic: redirect beats halt, halt beats normal sequencing
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      if (w_misaligned)    w_state_next = HALTED;
      else if (w_inflight) w_state_next = WAIT;
      else                 w_state_next = REQ;
    end else if (halt) begin
      w_state_next = HALTED;
    end else begin
      unique case (r_state)
        IDLE:    if (w_credit) w_state_next = REQ;
        REQ:     if (w_hs) w_state_next = WAIT;
        WAIT:    if (w_resp) w_state_next = w_credit ? REQ : IDLE;
        HALTED:  w_state_next = HALTED;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State, PC and outstanding-request bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_req_pc  <= RESET_PC;
      r_pending <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (redirect_valid) begin
        r_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_hs) begin
        r_pc <= pc_step(r_pc);
      end
      if (w_hs) r_req_pc <= r_pc;
      r_pending <= w_inflight;
      if (redirect_valid) begin
        r_drop <= w_inflight;
      end else if (w_resp) begin
        r_drop <= 1'b0;
      end
    end
  end

  ysyx_25060173_fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (w_push),
    .push_data(w_push_entry),
    .pop      (w_pop),
    .head     (w_head),
    .count    (w_count),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign imem_req_valid = (r_state == REQ);
  assign imem_req_addr  = r_pc;
  assign inst_valid     = ~w_empty;
  assign inst           = w_empty ? NOP_INST : w_head.inst;
  assign inst_pc        = w_empty ? 32'h0 : w_head.pc;
  assign inst_fault     = w_empty ? 1'b0 : w_head.fault;

endmodule

// File: tb/tb_ysyx_25060173_inst_fetch.sv
// Directed bench for the instruction fetch unit with a behavioural memory
// and a decoder-side log of consumed entries.
module tb_ysyx_25060173_inst_fetch;
  import ysyx_25060173_ifu_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        imem_resp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;

  int errors = 0;
  int checks = 0;

  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] err_addr = 32'hFFFF_FFF0;
  logic [31:0]  req_log[$];
  fetch_entry_t pop_log[$];

  always #5 clk = ~clk;

  ysyx_25060173_inst_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h1357_9BD0;
  endfunction

  // Memory model and decoder log, evaluated mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
      imem_resp_data  = 32'h0;
      if (mem_pend) begin
        if (mem_cnt <= 1) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = dat(mem_addr);
          imem_resp_err   = (mem_addr == err_addr);
          mem_pend        = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      if (rst_n && imem_req_valid && imem_req_ready) begin
        mem_pend = 1'b1;
        mem_cnt  = mem_lat;
        mem_addr = imem_req_addr;
        req_log.push_back(imem_req_addr);
        $display("req  addr=%h", imem_req_addr);
      end
      if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
        pop_log.push_back('{inst, inst_pc, inst_fault});
        $display("pop  pc=%h inst=%h fault=%b", inst_pc, inst, inst_fault);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    halt = 1'b0;
    inst_ready = 1'b0;
    imem_req_ready = 1'b1;
    mem_lat = 1;
    mem_pend = 1'b0;
    err_addr = 32'hFFFF_FFF0;
    tick(2);
    req_log.delete();
    pop_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_reqs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (req_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic wait_pops(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pop_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (imem_req_addr !== RPC) begin errors++; $display("FAIL reset_req_addr: got %h want %h", imem_req_addr, RPC); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    checks++; if (inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", inst, NOP); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    checks++; if (inst_fault !== 1'b0) begin errors++; $display("FAIL reset_inst_fault: got %b want 0", inst_fault); end
  endtask

  task automatic test_stream();
    bit ok;
    logic [31:0] exp;
    do_reset();
    inst_ready = 1'b1;
    tick(1);
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL stream_first_req: got %b want 1", imem_req_valid); end
    checks++; if (imem_req_addr !== RPC) begin errors++; $display("FAIL stream_first_addr: got %h want %h", imem_req_addr, RPC); end
    wait_pops(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stream_timeout: got %0d pops want 4", pop_log.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        exp = RPC + 32'(4 * i);
        checks++; if (req_log[i] !== exp) begin errors++; $display("FAIL stream_req%0d: got %h want %h", i, req_log[i], exp); end
        checks++; if (pop_log[i].pc !== exp) begin errors++; $display("FAIL stream_pc%0d: got %h want %h", i, pop_log[i].pc, exp); end
        checks++; if (pop_log[i].inst !== dat(exp) || pop_log[i].fault !== 1'b0) begin errors++; $display("FAIL stream_inst%0d: got %h/%b want %h/0", i, pop_log[i].inst, pop_log[i].fault, dat(exp)); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] exp;
    do_reset();
    tick(20);
    checks++; if (req_log.size() != 2) begin errors++; $display("FAIL bp_req_count: got %0d want 2", req_log.size()); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== RPC || inst !== dat(RPC)) begin errors++; $display("FAIL bp_head: got %b/%h/%h want 1/%h/%h", inst_valid, inst_pc, inst, RPC, dat(RPC)); end
    tick(3);
    checks++; if (inst_pc !== RPC || inst !== dat(RPC)) begin errors++; $display("FAIL bp_stable: got %h/%h want %h/%h", inst_pc, inst, RPC, dat(RPC)); end
    inst_ready = 1'b1;
    wait_pops(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d pops want 4", pop_log.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        exp = RPC + 32'(4 * i);
        checks++; if (pop_log[i].pc !== exp || pop_log[i].inst !== dat(exp)) begin errors++; $display("FAIL bp_order%0d: got %h/%h want %h/%h", i, pop_log[i].pc, pop_log[i].inst, exp, dat(exp)); end
      end
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    do_reset();
    mem_lat = 3;
    wait_reqs(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rdw_first_req_timeout: got %0d reqs want 1", req_log.size()); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_1000;
    tick(1);
    redirect_valid = 1'b0;
    mem_lat = 1;
    tick(2);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_stale_dropped: got inst_valid=%b pc=%h want 0", inst_valid, inst_pc); end
    for (int i = 0; i < 50; i++) begin
      if (inst_valid === 1'b1) break;
      tick(1);
    end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_1000 || inst !== dat(32'h8000_1000)) begin errors++; $display("FAIL rdw_new_head: got %b/%h/%h want 1/80001000/%h", inst_valid, inst_pc, inst, dat(32'h8000_1000)); end
    checks++; if (req_log.size() < 2 || req_log[1] !== 32'h8000_1000) begin errors++; $display("FAIL rdw_req_addr: got n=%0d addr=%h want 80001000", req_log.size(), (req_log.size() < 2) ? 32'h0 : req_log[1]); end
  endtask

  task automatic test_redirect_misaligned();
    int n;
    do_reset();
    tick(12);
    n = req_log.size();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    tick(1);
    redirect_valid = 1'b0;
    tick(8);
    checks++; if (req_log.size() != n || imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_no_req: got reqs=%0d valid=%b want %0d/0", req_log.size(), imem_req_valid, n); end
    checks++; if (inst_valid !== 1'b1 || inst !== NOP || inst_pc !== 32'h8000_0102 || inst_fault !== 1'b1) begin errors++; $display("FAIL mis_entry: got %b/%h/%h/%b want 1/%h/80000102/1", inst_valid, inst, inst_pc, inst_fault, NOP); end
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0 || pop_log.size() != 1) begin errors++; $display("FAIL mis_single: got valid=%b pops=%0d want 0/1", inst_valid, pop_log.size()); end
    tick(5);
    checks++; if (req_log.size() != n || inst_valid !== 1'b0) begin errors++; $display("FAIL mis_stall: got reqs=%0d valid=%b want %0d/0", req_log.size(), inst_valid, n); end
  endtask

  task automatic test_bus_error();
    bit ok;
    do_reset();
    err_addr = 32'h8000_0008;
    inst_ready = 1'b1;
    wait_pops(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL berr_timeout: got %0d pops want 4", pop_log.size()); end
    if (ok) begin
      checks++; if (pop_log[1].inst !== dat(32'h8000_0004) || pop_log[1].fault !== 1'b0) begin errors++; $display("FAIL berr_before: got %h/%b want %h/0", pop_log[1].inst, pop_log[1].fault, dat(32'h8000_0004)); end
      checks++; if (pop_log[2].inst !== NOP || pop_log[2].fault !== 1'b1 || pop_log[2].pc !== 32'h8000_0008) begin errors++; $display("FAIL berr_entry: got %h/%b/%h want %h/1/80000008", pop_log[2].inst, pop_log[2].fault, pop_log[2].pc, NOP); end
      checks++; if (pop_log[3].pc !== 32'h8000_000C || pop_log[3].fault !== 1'b0 || pop_log[3].inst !== dat(32'h8000_000C)) begin errors++; $display("FAIL berr_next: got %h/%b/%h want 8000000c/0/%h", pop_log[3].pc, pop_log[3].fault, pop_log[3].inst, dat(32'h8000_000C)); end
      checks++; if (req_log[3] !== 32'h8000_000C) begin errors++; $display("FAIL berr_req: got %h want 8000000c", req_log[3]); end
    end
  endtask

  task automatic test_halt_and_reset();
    bit ok;
    do_reset();
    mem_lat = 3;
    wait_reqs(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL halt_req_timeout: got %0d reqs want 1", req_log.size()); end
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    tick(10);
    checks++; if (req_log.size() != 1 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL halt_no_req: got reqs=%0d valid=%b want 1/0", req_log.size(), imem_req_valid); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== RPC || inst !== dat(RPC)) begin errors++; $display("FAIL halt_inflight: got %b/%h/%h want 1/%h/%h", inst_valid, inst_pc, inst, RPC, dat(RPC)); end
    // restart from HALTED, then reset while the second word is in flight
    redirect_valid = 1'b1;
    redirect_pc = RPC;
    tick(1);
    redirect_valid = 1'b0;
    wait_reqs(3, ok);
    checks++; if (!ok || inst_valid !== 1'b1) begin errors++; $display("FAIL halt_restart: got reqs=%0d valid=%b want 3/1", req_log.size(), inst_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== RPC) begin errors++; $display("FAIL areset_req: got %b/%h want 0/%h", imem_req_valid, imem_req_addr, RPC); end
    checks++; if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0 || inst_fault !== 1'b0) begin errors++; $display("FAIL areset_out: got %b/%h/%h/%b want 0/%h/0/0", inst_valid, inst, inst_pc, inst_fault, NOP); end
    @(posedge clk);
    #1;
    mem_lat = 1;
    pop_log.delete();
    rst_n = 1'b1;
    inst_ready = 1'b1;
    wait_pops(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL areset_timeout: got %0d pops want 2", pop_log.size()); end
    if (ok) begin
      checks++; if (pop_log[0].pc !== RPC || pop_log[0].inst !== dat(RPC)) begin errors++; $display("FAIL areset_late_ignored: got %h/%h want %h/%h", pop_log[0].pc, pop_log[0].inst, RPC, dat(RPC)); end
      checks++; if (pop_log[1].pc !== RPC + 32'd4 || pop_log[1].inst !== dat(RPC + 32'd4)) begin errors++; $display("FAIL areset_second: got %h/%h want %h/%h", pop_log[1].pc, pop_log[1].inst, RPC + 32'd4, dat(RPC + 32'd4)); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_misaligned();
    test_bus_error();
    test_halt_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
